// File: rtl/priority_resolver_n_if.sv
// ----------------------------------------------------------------------------
// priority_resolver_n_if
// Bus bundle between the PIC front end and the priority resolver.
//
// Signals (direction seen from the resolver, i.e. the slave modport):
//   irq          in   raw request lines, synchronous to the clock
//   imr          in   mask, 1 = channel masked
//   inta         in   acknowledge, active low
//   eoi_valid    in   one-cycle EOI / rotation command strobe
//   eoi_specific in   1 = EOI targets eoi_level, 0 = non-specific
//   eoi_rotate   in   1 = rotate priority with this EOI
//   set_pri      in   one-cycle strobe: lowest priority <= eoi_level
//   eoi_level    in   level operand for specific EOI / set_pri
//   int_req      out  interrupt request to the CPU (INT)
//   irr          out  interrupt request register
//   isr          out  in-service register
//   vec          out  acknowledged level index
//   vec_valid    out  one-cycle pulse, vec valid
// ----------------------------------------------------------------------------
interface priority_resolver_n_if #(
    parameter int N_IRQ = 8,
    parameter int LVL_W = $clog2(N_IRQ)
);
    logic [N_IRQ-1:0] irq;
    logic [N_IRQ-1:0] imr;
    logic             inta;
    logic             eoi_valid;
    logic             eoi_specific;
    logic             eoi_rotate;
    logic             set_pri;
    logic [LVL_W-1:0] eoi_level;
    logic             int_req;
    logic [N_IRQ-1:0] irr;
    logic [N_IRQ-1:0] isr;
    logic [LVL_W-1:0] vec;
    logic             vec_valid;

    modport master (
        output irq, imr, inta, eoi_valid, eoi_specific, eoi_rotate, set_pri, eoi_level,
        input  int_req, irr, isr, vec, vec_valid
    );

    modport slave (
        input  irq, imr, inta, eoi_valid, eoi_specific, eoi_rotate, set_pri, eoi_level,
        output int_req, irr, isr, vec, vec_valid
    );
endinterface

// File: rtl/priority_resolver_n.sv
// ----------------------------------------------------------------------------
// priority_resolver_n
// Interrupt priority resolver for an 8259A-compatible PIC. Holds the
// edge-triggered request register, the in-service register and the rotating
// lowest-priority pointer, drives INT and runs the two-pulse INTA sequence
// that hands the acknowledged level index to the data-bus block.
//
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_n_i  synchronous active-low reset
//   pic_s    priority_resolver_n_if slave modport (requests, mask, INTA,
//            EOI/rotation commands in; INT, IRR, ISR, VEC, VEC_VALID out)
//
// Build option:
//   PRI_RES_AEOI_EN  automatic EOI on the second INTA edge (ISR[W] clears
//                    as VEC_VALID rises, eoi_rotate at that edge rotates).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for first INTA falling edge, INT may be asserted
// ACK2  | level latched, waiting for second INTA edge, INT held low
// ----------------------------------------------------------------------------
module priority_resolver_n #(
    parameter int N_IRQ = 8,
    parameter int LVL_W = $clog2(N_IRQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    priority_resolver_n_if.slave pic_s
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK2 = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [LVL_W-1:0] idx;
        logic [LVL_W-1:0] rank;   // 0 = highest priority
    } pick_t;

    // Highest-priority set bit of v, with priority order lp+1, lp+2, ... mod N.
    // Scans from lowest to highest priority so the last hit is the winner.
    function automatic pick_t pick_highest(input logic [N_IRQ-1:0] v,
                                           input logic [LVL_W-1:0] lp);
        pick_t            r;
        int               pos;
        logic [LVL_W-1:0] pidx;
        r = '0;
        for (int k = N_IRQ; k >= 1; k--) begin
            pos = int'(lp) + k;
            if (pos >= N_IRQ) pos = pos - N_IRQ;
            pidx = pos[LVL_W-1:0];
            if (v[pidx]) begin
                r.found = 1'b1;
                r.idx   = pidx;
                r.rank  = LVL_W'(k - 1);
            end
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] irq_r_q, irq_r_d;       // registered IRQ
    logic [N_IRQ-1:0] irq_prev_q, irq_prev_d; // previous registered IRQ
    logic             inta_prev_q, inta_prev_d;
    logic [N_IRQ-1:0] irr_q, irr_d;
    logic [N_IRQ-1:0] isr_q, isr_d;
    logic [LVL_W-1:0] lp_q, lp_d;
    logic [LVL_W-1:0] w_q, w_d;
    logic [LVL_W-1:0] vec_q, vec_d;
    logic             vec_valid_q, vec_valid_d;
    logic             int_q, int_d;
`ifdef PRI_RES_AEOI_EN
    logic             spur_q, spur_d;
`endif

    pick_t            cand;
    pick_t            top_isr;
    logic             inta_fall;
    logic             lvl_ok;
    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] eoi_clr;
    logic [N_IRQ-1:0] ack_set;

    always_comb begin
        state_d     = state_q;
        irq_r_d     = pic_s.irq;
        irq_prev_d  = irq_r_q;
        inta_prev_d = pic_s.inta;
        lp_d        = lp_q;
        w_d         = w_q;
        vec_d       = vec_q;
        vec_valid_d = 1'b0;
`ifdef PRI_RES_AEOI_EN
        spur_d      = spur_q;
`endif
        eoi_clr     = '0;
        ack_set     = '0;

        irq_edge  = irq_r_q & ~irq_prev_q;
        inta_fall = inta_prev_q & ~pic_s.inta;
        lvl_ok    = int'(pic_s.eoi_level) < N_IRQ;
        cand      = pick_highest(irr_q & ~pic_s.imr, lp_q);
        top_isr   = pick_highest(isr_q, lp_q);

        // EOI takes precedence over SET_PRI in the same cycle.
        if (pic_s.eoi_valid) begin
            if (isr_q != '0) begin
                if (pic_s.eoi_specific) begin
                    if (lvl_ok) begin
                        eoi_clr[pic_s.eoi_level] = 1'b1;
                        if (pic_s.eoi_rotate) lp_d = pic_s.eoi_level;
                    end
                end else begin
                    eoi_clr[top_isr.idx] = 1'b1;
                    if (pic_s.eoi_rotate) lp_d = top_isr.idx;
                end
            end
        end else if (pic_s.set_pri && lvl_ok) begin
            lp_d = pic_s.eoi_level;
        end

        case (state_q)
            S_IDLE: begin
                if (inta_fall) begin
                    state_d = S_ACK2;
                    if (cand.found) begin
                        w_d               = cand.idx;
                        ack_set[cand.idx] = 1'b1;
`ifdef PRI_RES_AEOI_EN
                        spur_d            = 1'b0;
`endif
                    end else begin
                        w_d = LVL_W'(N_IRQ - 1);
`ifdef PRI_RES_AEOI_EN
                        spur_d = 1'b1;
`endif
                    end
                end
            end
            S_ACK2: begin
                if (inta_fall) begin
                    state_d     = S_IDLE;
                    vec_d       = w_q;
                    vec_valid_d = 1'b1;
`ifdef PRI_RES_AEOI_EN
                    if (!spur_q) begin
                        eoi_clr[w_q] = 1'b1;
                        if (pic_s.eoi_rotate) lp_d = w_q;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear before set: an acknowledge wins over a same-cycle EOI on one bit.
        isr_d = (isr_q & ~eoi_clr) | ack_set;
        irr_d = (irr_q & ~ack_set) | irq_edge;

        // INT is evaluated from the current registers, forced low when leaving IDLE.
        int_d = (state_d == S_IDLE) && cand.found &&
                (!top_isr.found || (cand.rank < top_isr.rank));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            irq_r_q     <= '1;
            irq_prev_q  <= '1;
            inta_prev_q <= 1'b0;
            irr_q       <= '0;
            isr_q       <= '0;
            lp_q        <= LVL_W'(N_IRQ - 1);
            w_q         <= '0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            int_q       <= 1'b0;
`ifdef PRI_RES_AEOI_EN
            spur_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            irq_r_q     <= irq_r_d;
            irq_prev_q  <= irq_prev_d;
            inta_prev_q <= inta_prev_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            lp_q        <= lp_d;
            w_q         <= w_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            int_q       <= int_d;
`ifdef PRI_RES_AEOI_EN
            spur_q      <= spur_d;
`endif
        end
    end

    assign pic_s.int_req   = int_q;
    assign pic_s.irr       = irr_q;
    assign pic_s.isr       = isr_q;
    assign pic_s.vec       = vec_q;
    assign pic_s.vec_valid = vec_valid_q;

endmodule

// File: tb/tb_priority_resolver_n.sv
// ----------------------------------------------------------------------------
// tb_priority_resolver_n
// Directed bench for priority_resolver_n: an 8-channel instance for the main
// sequences and a 6-channel instance for out-of-range level operands.
// ----------------------------------------------------------------------------
module tb_priority_resolver_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    priority_resolver_n_if #(.N_IRQ(8)) pif ();
    priority_resolver_n_if #(.N_IRQ(6)) pif6 ();

    priority_resolver_n #(.N_IRQ(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .pic_s   (pif.slave)
    );

    priority_resolver_n #(.N_IRQ(6)) dut6 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .pic_s   (pif6.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Two INTA pulses on the 8-channel instance, checking the vector handoff.
    task automatic ack(input string tag, input int exp_vec);
        pif.inta = 1'b0; tick();
        chk({tag, "_int_low"}, 32'(pif.int_req), 0);
        pif.inta = 1'b1; tick();
        chk({tag, "_vv_early"}, 32'(pif.vec_valid), 0);
        pif.inta = 1'b0; tick();
        chk({tag, "_vv"}, 32'(pif.vec_valid), 1);
        chk({tag, "_vec"}, 32'(pif.vec), exp_vec);
        pif.inta = 1'b1; tick();
        chk({tag, "_vv_clr"}, 32'(pif.vec_valid), 0);
    endtask

    task automatic eoi(input logic spec, input logic rot, input logic [2:0] lvl);
        pif.eoi_valid    = 1'b1;
        pif.eoi_specific = spec;
        pif.eoi_rotate   = rot;
        pif.eoi_level    = lvl;
        tick();
        pif.eoi_valid    = 1'b0;
        pif.eoi_specific = 1'b0;
        pif.eoi_rotate   = 1'b0;
    endtask

    initial begin
        pif.irq = '0; pif.imr = '0; pif.inta = 1'b1;
        pif.eoi_valid = 1'b0; pif.eoi_specific = 1'b0; pif.eoi_rotate = 1'b0;
        pif.set_pri = 1'b0; pif.eoi_level = '0;
        pif6.irq = '0; pif6.imr = '0; pif6.inta = 1'b1;
        pif6.eoi_valid = 1'b0; pif6.eoi_specific = 1'b0; pif6.eoi_rotate = 1'b0;
        pif6.set_pri = 1'b0; pif6.eoi_level = '0;

        rst_n = 1'b0;
        tick(3);
        chk("rst_int", 32'(pif.int_req), 0);
        chk("rst_irr", 32'(pif.irr), 0);
        chk("rst_isr", 32'(pif.isr), 0);
        chk("rst_vec", 32'(pif.vec), 0);
        chk("rst_vv", 32'(pif.vec_valid), 0);
        rst_n = 1'b1;
        tick(2);

        // Fixed priority: IRQ2 and IRQ5 rise together.
        pif.irq = 8'h24;
        tick();
        chk("lat_irr_k", 32'(pif.irr), 0);
        tick();
        chk("lat_irr_k1", 32'(pif.irr), 32'h24);
        chk("lat_int_k1", 32'(pif.int_req), 0);
        tick();
        chk("lat_int_k2", 32'(pif.int_req), 1);
        ack("fixed", 2);
        chk("fixed_isr", 32'(pif.isr), 32'h04);
        chk("fixed_irr", 32'(pif.irr), 32'h20);
        tick();
        chk("nest_ir5_int", 32'(pif.int_req), 0);

        // Nesting: IRQ0 outranks in-service IR2.
        pif.irq = 8'h25;
        tick(3);
        chk("nest_ir0_int", 32'(pif.int_req), 1);
        ack("nest", 0);
        chk("nest_isr", 32'(pif.isr), 32'h05);
        eoi(1'b0, 1'b0, 3'd0);
        chk("nest_eoi_isr", 32'(pif.isr), 32'h04);
        tick();
        chk("nest_eoi_int", 32'(pif.int_req), 0);
        eoi(1'b0, 1'b0, 3'd0);
        chk("nest_eoi2_isr", 32'(pif.isr), 0);
        tick();
        chk("ir5_int", 32'(pif.int_req), 1);
        ack("ir5", 5);
        eoi(1'b0, 1'b0, 3'd0);

        // Rotation: rotating EOI on IR3 makes IR4 the highest priority.
        pif.irq = 8'h00; tick();
        pif.irq = 8'h08; tick(3);
        ack("ir3", 3);
        chk("ir3_isr", 32'(pif.isr), 32'h08);
        eoi(1'b0, 1'b1, 3'd0);
        chk("rot_eoi_isr", 32'(pif.isr), 0);
        pif.irq = 8'h19; tick(3);
        chk("rot_int", 32'(pif.int_req), 1);
        ack("rot", 4);
        chk("rot_isr", 32'(pif.isr), 32'h10);
        chk("rot_irr", 32'(pif.irr), 32'h01);
        eoi(1'b0, 1'b0, 3'd0);
        tick();
        ack("rot_ir0", 0);
        eoi(1'b0, 1'b0, 3'd0);

        // SET_PRI: lowest = 6 makes IR7 highest.
        pif.set_pri = 1'b1; pif.eoi_level = 3'd6; tick();
        pif.set_pri = 1'b0;
        pif.irq = 8'h00; tick();
        pif.irq = 8'h81; tick(3);
        ack("setpri", 7);
        chk("setpri_isr", 32'(pif.isr), 32'h80);
        chk("setpri_irr", 32'(pif.irr), 32'h01);

        // SET_PRI colliding with EOI is dropped, LP stays 6.
        pif.eoi_valid = 1'b1; pif.set_pri = 1'b1; pif.eoi_level = 3'd0;
        tick();
        pif.eoi_valid = 1'b0; pif.set_pri = 1'b0;
        chk("collide_isr", 32'(pif.isr), 0);
        pif.irq = 8'h83; tick(3);
        ack("collide", 0);
        eoi(1'b0, 1'b0, 3'd0);
        tick();
        ack("ir1", 1);
        eoi(1'b1, 1'b0, 3'd5);
        chk("spec_eoi_other", 32'(pif.isr), 32'h02);
        eoi(1'b1, 1'b0, 3'd1);
        chk("spec_eoi_hit", 32'(pif.isr), 0);

        // Spurious: IRQ3 masked.
        pif.irq = 8'h00; tick();
        pif.imr = 8'h08; pif.irq = 8'h08; tick(3);
        chk("spur_int", 32'(pif.int_req), 0);
        chk("spur_irr_pre", 32'(pif.irr), 32'h08);
        ack("spur", 7);
        chk("spur_isr", 32'(pif.isr), 0);
        chk("spur_irr", 32'(pif.irr), 32'h08);

        // Automatic EOI (or its absence in the default build).
        rst_n = 1'b0; tick();
        rst_n = 1'b1; pif.imr = 8'h00; tick();
        pif.irq = 8'h0A; tick(3);
        chk("aeoi_int", 32'(pif.int_req), 1);
        ack("aeoi", 1);
`ifdef PRI_RES_AEOI_EN
        chk("aeoi_isr", 32'(pif.isr), 0);
`else
        chk("noaeoi_isr", 32'(pif.isr), 32'h02);
`endif
        eoi(1'b0, 1'b0, 3'd0);
        chk("aeoi_clean_isr", 32'(pif.isr), 0);

        // Reset between the INTA pulses aborts the acknowledge.
        pif.irq = 8'h08; tick();
        pif.irq = 8'h0A; tick(3);
        pif.inta = 1'b0; tick();
        chk("mid_isr", 32'(pif.isr), 32'h02);
        pif.inta = 1'b1; rst_n = 1'b0; tick();
        chk("mid_rst_isr", 32'(pif.isr), 0);
        chk("mid_rst_int", 32'(pif.int_req), 0);
        rst_n = 1'b1; tick();
        pif.inta = 1'b0; tick();
        chk("mid_vv", 32'(pif.vec_valid), 0);
        chk("mid_isr2", 32'(pif.isr), 0);
        chk("mid_irr", 32'(pif.irr), 0);
        chk("mid_vec", 32'(pif.vec), 0);
        chk("mid_int", 32'(pif.int_req), 0);
        pif.inta = 1'b1; tick();
        chk("mid_vv2", 32'(pif.vec_valid), 0);

        // Six channels: level 7 is out of range for SET_PRI and specific EOI.
        pif6.set_pri = 1'b1; pif6.eoi_level = 3'd7; tick();
        pif6.set_pri = 1'b0;
        pif6.irq = 6'h21; tick(3);
        chk("n6_int", 32'(pif6.int_req), 1);
        pif6.inta = 1'b0; tick();
        pif6.inta = 1'b1; tick();
        pif6.inta = 1'b0; tick();
        chk("n6_vv", 32'(pif6.vec_valid), 1);
        chk("n6_vec", 32'(pif6.vec), 0);
        pif6.inta = 1'b1; tick();
        chk("n6_isr", 32'(pif6.isr), 32'h01);
        pif6.eoi_valid = 1'b1; pif6.eoi_specific = 1'b1; pif6.eoi_level = 3'd7; tick();
        pif6.eoi_valid = 1'b0;
        chk("n6_eoi_oor", 32'(pif6.isr), 32'h01);
        pif6.eoi_valid = 1'b1; pif6.eoi_level = 3'd0; tick();
        pif6.eoi_valid = 1'b0; pif6.eoi_specific = 1'b0;
        chk("n6_eoi_ok", 32'(pif6.isr), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
